// File: rtl/boot_pkg.sv
`default_nettype none
// ============================================================================
// Package : boot_pkg
// Purpose : Shared definitions for the instruction-memory boot loader:
//           loader state encoding, word geometry and length-field width.
// Rev     : 1.0  initial release
// ============================================================================
package boot_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_RUN  = 3'd5,
    S_ERR  = 3'd6
  } state_e;

endpackage
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
// Module  : byte_packer
// Purpose : Shifts bytes into a little-endian 32-bit word (first byte ends up
//           in bits [7:0]) and pulses word_valid_o for one cycle after the
//           byte flagged as last of the word has been shifted in.
// Ports   : clk          - clock
//           rst          - asynchronous active-low reset
//           shift_i      - shift byte_i in this cycle
//           byte_i       - incoming byte
//           last_i       - byte_i is the final byte of the word
//           word_o       - assembled word (valid while word_valid_o is high)
//           word_valid_o - one-cycle pulse, word_o complete
// Rev     : 1.0  initial release
// ============================================================================
module byte_packer
  import boot_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        shift_i,
  input  logic [7:0]                  byte_i,
  input  logic                        last_i,
  output logic [BYTES_PER_WORD*8-1:0] word_o,
  output logic                        word_valid_o
);

  logic [BYTES_PER_WORD*8-1:0] word_q;
  logic                        valid_q;

  // New bytes enter at the top and drift down, so after four shifts the
  // first byte received sits in the least significant lane.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= shift_i & last_i;
      if (shift_i) begin
        word_q <= {byte_i, word_q[BYTES_PER_WORD*8-1:8]};
      end
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module  : imem_boot_loader
// Purpose : Receives a length-prefixed, XOR-checksummed byte stream, writes
//           the little-endian instruction words into instruction memory from
//           word 0 upward and holds the core in reset until the image is
//           complete and verified.
// Ports   : clk, rst (async active-low)
//           in_valid/in_data/in_ready - byte stream handshake
//           imem_we/imem_addr/imem_wdata - registered memory write port
//           cpu_rst   - reset to the core, low only once the image is good
//           load_done - image verified (sticky)
//           load_err  - length or checksum failure (sticky)
// Rev     : 1.0  initial release
// ============================================================================
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err
);

  // Memory capacity in words, widened by one bit so 2**ADDR_W is representable.
  localparam int unsigned    CAP_I = 2 ** ADDR_W;
  localparam logic [LEN_W:0] CAP   = CAP_I[LEN_W:0];

  state_e             state_q,    state_d;
  logic [LEN_W-1:0]   len_q,      len_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [LEN_W:0]     word_cnt_q, word_cnt_d;
  logic [7:0]         csum_q,     csum_d;
  logic [ADDR_W-1:0]  addr_q,     addr_d;

  logic               xfer;
  logic [LEN_W-1:0]   len_full;
  logic               pack_shift;
  logic               pack_last;

  assign in_ready   = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                      (state_q == S_DATA) || (state_q == S_CSUM);
  assign xfer       = in_valid & in_ready;
  assign len_full   = {in_data, len_q[7:0]};
  assign pack_shift = xfer && (state_q == S_DATA);
  assign pack_last  = (byte_cnt_q == 2'd3);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    csum_d     = csum_q;
    addr_d     = addr_q;

    // The checksum byte itself is compared, never folded in.
    if (xfer && (state_q != S_CSUM)) begin
      csum_d = csum_q ^ in_data;
    end

    case (state_q)
      S_IDLE: state_d = S_LEN0;
      S_LEN0: begin
        if (xfer) begin
          len_d[7:0] = in_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (xfer) begin
          len_d = len_full;
          if ({1'b0, len_full} > CAP) begin
            state_d = S_ERR;
          end else if (len_full == '0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (pack_last) begin
            // Address is captured alongside the word so both present together.
            addr_d     = word_cnt_q[ADDR_W-1:0];
            word_cnt_d = word_cnt_q + 1'b1;
            if ((word_cnt_q + 1'b1) == {1'b0, len_q}) begin
              state_d = S_CSUM;
            end
          end
        end
      end
      S_CSUM: begin
        if (xfer) begin
          state_d = (in_data == csum_q) ? S_RUN : S_ERR;
        end
      end
      S_RUN:   state_d = S_RUN;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      csum_q     <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      csum_q     <= csum_d;
      addr_q     <= addr_d;
    end
  end

  byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .shift_i      (pack_shift),
    .byte_i       (in_data),
    .last_i       (pack_last),
    .word_o       (imem_wdata),
    .word_valid_o (imem_we)
  );

  assign imem_addr = addr_q;
  assign cpu_rst   = (state_q != S_RUN);
  assign load_done = (state_q == S_RUN);
  assign load_err  = (state_q == S_ERR);

endmodule
`default_nettype wire
